// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
// Build option: FIFO_UART_TX_PARITY_EN adds an even-parity bit to every frame.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit
// (tick) and the cycle before it (pre_tick), restartable by clear.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick     = (r_cnt == LAST_CNT);
  // Lets the registered byte_done line up with the final STOP cycle.
  assign pre_tick = (r_cnt == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the 8-deep FIFO and serialises them as start/8 data LSB-first/stop.
// Build option: FIFO_UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              r_busy;
  logic              r_byte_done;
  logic              w_clear;
  logic              w_tick;
  logic              w_pre_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_clear        = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          w_state_next = POP;
        end
      end
      POP: begin
        w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next   = START;
        w_clear        = 1'b1;
        w_shift_next   = fifo_dout;
        w_bit_cnt_next = '0;
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // tx is registered, so its next value is decoded from the next state.
  always_comb begin
    w_tx_next = UART_IDLE_LVL;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= UART_IDLE_LVL;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_tx        <= w_tx_next;
      r_busy      <= (w_state_next != IDLE);
      r_byte_done <= (r_state == STOP) && w_pre_tick;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= ^fifo_dout;
    end
  end
`endif

  assign fifo_rd_en = (r_state == POP);
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign byte_done  = r_byte_done;

endmodule
